mtpsa_digest_split: RTL and testbench

- Sits directly downstream of the MTPSA ingress SDNet stage.
- Consumes its packet stream, whose 304-bit tuser carries a 256-bit digest above the 48-bit standard metadata.
- Forwards packets with a 128-bit SUME-format tuser. When send_dig_to_cpu is set, it captures {src_port, user_id, digest} into a digest FIFO and emits it on a separate single-beat AXI-Stream toward the DMA/CPU path.
- Keeps packet, digest and digest-drop statistics.

---
 rtl/mtpsa_digest_split.sv | 161 ++++++++++++++++
 tb/tb_mtpsa_digest_split.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtpsa_digest_split.sv
`default_nettype none
// ============================================================================
// Module      : mtpsa_digest_split
// Description : Zero-latency packet pass-through that strips the 256-bit
//               digest from tuser, queues requested digests for the CPU path
//               and keeps packet/digest/drop statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module mtpsa_digest_split #(
  parameter int C_AXIS_DATA_WIDTH    = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 304,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int DIGEST_WIDTH         = 256,
  parameter int DIG_FIFO_DEPTH       = 16
) (
  input  logic                              axis_aclk,
  input  logic                              axis_rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [DIGEST_WIDTH+15:0]          m_dig_tdata,
  output logic                              m_dig_tvalid,
  input  logic                              m_dig_tready,
  output logic [31:0]                       pkt_cnt,
  output logic [31:0]                       dig_cnt,
  output logic [31:0]                       dig_drop_cnt
);

  localparam int c_REC_W = DIGEST_WIDTH + 16;
  localparam int c_PTR_W = $clog2(DIG_FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(DIG_FIFO_DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DIG_FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  localparam logic [0:0] c_ST_IN_PKT = 1'b0;
  localparam logic [0:0] c_ST_SOP    = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic                w_sop;
  logic                w_beat;
  logic                w_capture;
  logic                w_pop;
  logic                w_full;
  logic                w_wr_en;
  logic                w_drop;
  logic [c_REC_W-1:0]  w_rec;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W-1:0]  w_rd_ptr_nxt;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_CNT_W-1:0]  w_count_nxt;
  logic [c_REC_W-1:0]  r_mem [DIG_FIFO_DEPTH];
  logic [c_REC_W-1:0]  r_dig_tdata;
  logic                r_dig_tvalid;
  logic [31:0]         r_pkt_cnt;
  logic [31:0]         r_dig_cnt;
  logic [31:0]         r_drop_cnt;

  // Packet path: pure wires, never stalled by the digest side.
  assign m_axis_tvalid = s_axis_tvalid;
  assign s_axis_tready = m_axis_tready;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;

  always_comb begin
    m_axis_tuser        = '0;
    m_axis_tuser[39:0]  = s_axis_tuser[39:0];
    m_axis_tuser[47:41] = s_axis_tuser[47:41];
  end

  assign w_beat = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) r_state <= c_ST_SOP;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_beat) w_state_nxt = s_axis_tlast ? c_ST_SOP : c_ST_IN_PKT;
  end

  always_comb begin
    w_sop = (r_state == c_ST_SOP);
  end

  assign w_rec     = {s_axis_tuser[23:16], s_axis_tuser[39:32], s_axis_tuser[48 +: DIGEST_WIDTH]};
  assign w_capture = w_beat & w_sop & s_axis_tuser[40];
  assign w_pop     = r_dig_tvalid & m_dig_tready;
  assign w_full    = (r_count == c_FULL);
  // A pop on a full FIFO frees the slot the incoming record lands in.
  assign w_wr_en   = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + c_PTR_ONE : r_rd_ptr;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + c_CNT_ONE;
      2'b01:   w_count_nxt = r_count - c_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_rec;
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dig_tvalid <= 1'b0;
      r_dig_tdata  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      r_dig_tvalid <= (w_count_nxt != '0);
      // Head register: bypass the write when it becomes the next head.
      if (w_count_nxt != '0) begin
        if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) r_dig_tdata <= w_rec;
        else                                       r_dig_tdata <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      r_pkt_cnt  <= '0;
      r_dig_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_beat && w_sop && r_pkt_cnt != 32'hFFFF_FFFF) r_pkt_cnt  <= r_pkt_cnt + 32'd1;
      if (w_wr_en && r_dig_cnt != 32'hFFFF_FFFF)         r_dig_cnt  <= r_dig_cnt + 32'd1;
      if (w_drop && r_drop_cnt != 32'hFFFF_FFFF)         r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign m_dig_tdata  = r_dig_tdata;
  assign m_dig_tvalid = r_dig_tvalid;
  assign pkt_cnt      = r_pkt_cnt;
  assign dig_cnt      = r_dig_cnt;
  assign dig_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mtpsa_digest_split.sv
`default_nettype none
// ============================================================================
// Module      : tb_mtpsa_digest_split
// Description : Directed self-checking bench for mtpsa_digest_split.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtpsa_digest_split;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [303:0] s_tuser;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [255:0] m_tdata;
  logic [31:0]  m_tkeep;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [271:0] d_tdata;
  logic         d_tvalid;
  logic         d_tready;
  logic [31:0]  pkt_cnt;
  logic [31:0]  dig_cnt;
  logic [31:0]  drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mtpsa_digest_split dut (
    .axis_aclk    (clk),
    .axis_rst     (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tuser (s_tuser),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tuser (m_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_dig_tdata  (d_tdata),
    .m_dig_tvalid (d_tvalid),
    .m_dig_tready (d_tready),
    .pkt_cnt      (pkt_cnt),
    .dig_cnt      (dig_cnt),
    .dig_drop_cnt (drop_cnt)
  );

  function automatic logic [303:0] mk_user(input logic [7:0] sd, input logic [7:0] uid,
                                           input logic [7:0] dst, input logic [7:0] src,
                                           input logic [15:0] len, input logic [255:0] dig);
    return {dig, sd, uid, dst, src, len};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic last, input logic [303:0] u);
    s_tvalid = v;
    s_tlast  = last;
    s_tuser  = u;
    s_tdata  = {8{u[31:0]}};
    s_tkeep  = u[31:0] ^ 32'h5A5A_0F0F;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_tready = 1'b1; d_tready = 1'b0;
    drive(1'b1, 1'b1, mk_user(8'h01, 8'h11, 8'h22, 8'h33, 16'd60, {32{8'h77}}));
    tick(); tick();
    n_cmp++; if (pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_pkt_cnt got %0d want 0", pkt_cnt); end
    n_cmp++; if (dig_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_dig_cnt got %0d want 0", dig_cnt); end
    n_cmp++; if (drop_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt); end
    n_cmp++; if (d_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_dig_valid got %b want 0", d_tvalid); end
    n_cmp++; if (d_tdata !== 272'd0) begin n_fail++; $display("FAIL rst_dig_data got %h want 0", d_tdata); end
    n_cmp++; if (m_tvalid !== 1'b1 || m_tdata !== s_tdata) begin n_fail++; $display("FAIL rst_passthru got v=%b want v=1 data follow", m_tvalid); end
    m_tready = 1'b0; #1;
    n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready got %b want 0", s_tready); end
    m_tready = 1'b1;
    s_tvalid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    d_tready = 1'b1; m_tready = 1'b1;
    drive(1'b1, 1'b1, mk_user(8'h01, 8'h03, 8'h04, 8'h01, 16'd64, {32{8'hA5}}));
    n_cmp++; if (m_tuser !== {80'd0, 7'd0, 1'b0, 8'h03, 8'h04, 8'h01, 16'd64})
      begin n_fail++; $display("FAIL single_tuser got %h want %h", m_tuser, {80'd0, 8'h00, 8'h03, 8'h04, 8'h01, 16'd64}); end
    n_cmp++; if (m_tkeep !== s_tkeep || m_tlast !== 1'b1)
      begin n_fail++; $display("FAIL single_keep_last got %h/%b want %h/1", m_tkeep, m_tlast, s_tkeep); end
    n_cmp++; if (d_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", d_tvalid); end
    tick();
    s_tvalid = 1'b0;
    n_cmp++; if (d_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_dig_valid got %b want 1", d_tvalid); end
    n_cmp++; if (d_tdata !== {8'h01, 8'h03, {32{8'hA5}}})
      begin n_fail++; $display("FAIL single_dig_data got %h want %h", d_tdata, {8'h01, 8'h03, {32{8'hA5}}}); end
    n_cmp++; if (pkt_cnt !== 32'd1 || dig_cnt !== 32'd1)
      begin n_fail++; $display("FAIL single_counts got pkt=%0d dig=%0d want 1/1", pkt_cnt, dig_cnt); end
    tick();
    n_cmp++; if (d_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_popped got %b want 0", d_tvalid); end
    drive(1'b1, 1'b1, mk_user(8'hFF, 8'h09, 8'h08, 8'h07, 16'd100, {32{8'h5C}}));
    n_cmp++; if (m_tuser[47:40] !== 8'hFE) begin n_fail++; $display("FAIL single_sd_bits got %h want fe", m_tuser[47:40]); end
    tick();
    s_tvalid = 1'b0;
    d_tready = 1'b0;
  endtask

  task automatic test_multi_beat();
    logic [7:0] b;
    do_reset();
    d_tready = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = 8'h10 + 8'(i);
      drive(1'b1, i == 3, mk_user(8'h01, b, 8'h00, 8'h02, 16'd128, {32{b}}));
      tick();
    end
    drive(1'b1, 1'b1, mk_user(8'h00, 8'h20, 8'h00, 8'h02, 16'd32, {32{8'h20}}));
    tick();
    s_tvalid = 1'b0;
    n_cmp++; if (pkt_cnt !== 32'd2 || dig_cnt !== 32'd1)
      begin n_fail++; $display("FAIL multi_counts got pkt=%0d dig=%0d want 2/1", pkt_cnt, dig_cnt); end
    n_cmp++; if (d_tdata !== {8'h02, 8'h10, {32{8'h10}}})
      begin n_fail++; $display("FAIL multi_dig_data got %h want sop record", d_tdata); end
    d_tready = 1'b1;
    tick();
    n_cmp++; if (d_tvalid !== 1'b0) begin n_fail++; $display("FAIL multi_single_entry got %b want 0", d_tvalid); end
    d_tready = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [271:0] exp_q[$];
    logic [7:0]   b;
    do_reset();
    d_tready = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      b = 8'(i);
      drive(1'b1, 1'b1, mk_user(8'h01, 8'h40 + b, 8'h00, b, 16'd64, {32{b}}));
      n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL full_tready beat %0d got %b want 1", i, s_tready); end
      if (i < 16) exp_q.push_back({b, 8'h40 + b, {32{b}}});
      tick();
    end
    s_tvalid = 1'b0;
    tick();
    n_cmp++; if (dig_cnt !== 32'd16 || drop_cnt !== 32'd2 || pkt_cnt !== 32'd18)
      begin n_fail++; $display("FAIL full_counts got dig=%0d drop=%0d pkt=%0d want 16/2/18", dig_cnt, drop_cnt, pkt_cnt); end
    tick();
    n_cmp++; if (d_tvalid !== 1'b1 || d_tdata !== exp_q[0])
      begin n_fail++; $display("FAIL full_hold got v=%b %h want 1 %h", d_tvalid, d_tdata, exp_q[0]); end
    d_tready = 1'b1;
    drive(1'b1, 1'b1, mk_user(8'h01, 8'hE1, 8'h00, 8'hE0, 16'd64, {32{8'hEE}}));
    tick();
    d_tready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({8'hE0, 8'hE1, {32{8'hEE}}});
    n_cmp++; if (dig_cnt !== 32'd17 || drop_cnt !== 32'd2)
      begin n_fail++; $display("FAIL full_pop_capture got dig=%0d drop=%0d want 17/2", dig_cnt, drop_cnt); end
    drive(1'b1, 1'b1, mk_user(8'h01, 8'hF1, 8'h00, 8'hF0, 16'd64, {32{8'hFF}}));
    tick();
    s_tvalid = 1'b0;
    n_cmp++; if (dig_cnt !== 32'd17 || drop_cnt !== 32'd3)
      begin n_fail++; $display("FAIL full_still_full got dig=%0d drop=%0d want 17/3", dig_cnt, drop_cnt); end
    d_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (d_tvalid !== 1'b1 || d_tdata !== exp_q[k])
        begin n_fail++; $display("FAIL drain_%0d got v=%b %h want 1 %h", k, d_tvalid, d_tdata, exp_q[k]); end
      tick();
    end
    n_cmp++; if (d_tvalid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", d_tvalid); end
    d_tready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    d_tready = 1'b0; m_tready = 1'b1;
    drive(1'b1, 1'b0, mk_user(8'h01, 8'h06, 8'h00, 8'h05, 16'd96, {32{8'hB0}}));
    tick();
    m_tready = 1'b0;
    drive(1'b1, 1'b0, mk_user(8'h01, 8'h06, 8'h00, 8'h05, 16'd96, {32{8'hB1}}));
    n_cmp++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready_low got %b want 0", s_tready); end
    tick();
    m_tready = 1'b1; #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL bp_tready_high got %b want 1", s_tready); end
    tick();
    m_tready = 1'b0;
    drive(1'b1, 1'b1, mk_user(8'h01, 8'h06, 8'h00, 8'h05, 16'd96, {32{8'hB2}}));
    tick();
    m_tready = 1'b1; #1;
    tick();
    s_tvalid = 1'b0;
    n_cmp++; if (pkt_cnt !== 32'd1 || dig_cnt !== 32'd1)
      begin n_fail++; $display("FAIL bp_counts got pkt=%0d dig=%0d want 1/1", pkt_cnt, dig_cnt); end
    m_tready = 1'b0;
    drive(1'b1, 1'b1, mk_user(8'h01, 8'h08, 8'h00, 8'h07, 16'd64, {32{8'hC0}}));
    tick();
    n_cmp++; if (pkt_cnt !== 32'd1 || dig_cnt !== 32'd1)
      begin n_fail++; $display("FAIL bp_stalled_sop got pkt=%0d dig=%0d want 1/1", pkt_cnt, dig_cnt); end
    m_tready = 1'b1; #1;
    tick();
    s_tvalid = 1'b0;
    n_cmp++; if (pkt_cnt !== 32'd2 || dig_cnt !== 32'd2)
      begin n_fail++; $display("FAIL bp_next_pkt got pkt=%0d dig=%0d want 2/2", pkt_cnt, dig_cnt); end
    n_cmp++; if (d_tdata !== {8'h05, 8'h06, {32{8'hB0}}})
      begin n_fail++; $display("FAIL bp_head got %h want first record", d_tdata); end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] b;
    do_reset();
    d_tready = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = 8'h30 + 8'(i);
      drive(1'b1, 1'b1, mk_user(8'h01, b, 8'h00, b, 16'd64, {32{b}}));
      tick();
    end
    drive(1'b1, 1'b0, mk_user(8'h00, 8'h00, 8'h00, 8'h00, 16'd96, {32{8'h44}}));
    tick();
    n_cmp++; if (dig_cnt !== 32'd3 || d_tvalid !== 1'b1)
      begin n_fail++; $display("FAIL rmid_queued got dig=%0d v=%b want 3/1", dig_cnt, d_tvalid); end
    rst = 1'b1;
    drive(1'b1, 1'b0, mk_user(8'h01, 8'h00, 8'h00, 8'h00, 16'd96, {32{8'h45}}));
    tick();
    rst = 1'b0;
    n_cmp++; if (d_tvalid !== 1'b0 || d_tdata !== 272'd0)
      begin n_fail++; $display("FAIL rmid_dig_cleared got v=%b %h want 0 0", d_tvalid, d_tdata); end
    n_cmp++; if (pkt_cnt !== 32'd0 || dig_cnt !== 32'd0 || drop_cnt !== 32'd0)
      begin n_fail++; $display("FAIL rmid_counts got %0d/%0d/%0d want 0/0/0", pkt_cnt, dig_cnt, drop_cnt); end
    drive(1'b1, 1'b0, mk_user(8'h01, 8'h0A, 8'h00, 8'h09, 16'd96, {32{8'hD0}}));
    tick();
    s_tvalid = 1'b0;
    n_cmp++; if (d_tvalid !== 1'b1 || d_tdata !== {8'h09, 8'h0A, {32{8'hD0}}})
      begin n_fail++; $display("FAIL rmid_new_sop got v=%b %h want 1 new record", d_tvalid, d_tdata); end
    n_cmp++; if (pkt_cnt !== 32'd1 || dig_cnt !== 32'd1)
      begin n_fail++; $display("FAIL rmid_new_counts got pkt=%0d dig=%0d want 1/1", pkt_cnt, dig_cnt); end
  endtask

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
    s_tuser = '0; m_tready = 1'b1; d_tready = 1'b0;
    test_reset();
    test_single();
    test_multi_beat();
    test_fifo_full();
    test_backpressure();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
